conv4_window_feeder: RTL and testbench

Sequencer that drives the 4×4 FP16 convolution unit. On `start` it:
- reads four kernel rows from a shared row-group memory port and pushes them as kernel-load beats;
- sweeps the image in vertical strips, one 4-pixel row group per beat;
- issues the `valid_out` capture pulse for every completed window.

It sits between the feature-map/kernel buffer and the convolution unit. It generates `valid_in`, `kernel_load`, `valid_out` and the four `data_in` lanes the convolution unit consumes.

---
 rtl/conv4_window_feeder.sv | 187 ++++++++++++++++++
 tb/tb_conv4_window_feeder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/conv4_window_feeder.sv
// Sequencer for the 4x4 FP16 convolution unit: loads four kernel rows, then sweeps the image in
// vertical strips one row group per cycle. Define CONV_FEED_ZERO_PAD_EN for a PADDING-wide zero border.
module conv4_feed_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  lane_ok_i,
  input  logic [DATA_WIDTH-1:0] raw_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  assign data_o = lane_ok_i ? raw_i : '0;
endmodule

module conv4_window_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 4,
  parameter int IMG_H       = 32,
  parameter int IMG_W       = 32,
  parameter int PADDING     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd_en,
  output logic                          mem_kernel_sel,
  output logic [$clog2(IMG_H):0]        mem_row,
  output logic signed [$clog2(IMG_W):0] mem_col,
  input  logic [4*DATA_WIDTH-1:0]       mem_rd_data,
  output logic [DATA_WIDTH-1:0]         data_in0,
  output logic [DATA_WIDTH-1:0]         data_in1,
  output logic [DATA_WIDTH-1:0]         data_in2,
  output logic [DATA_WIDTH-1:0]         data_in3,
  output logic                          valid_in,
  output logic                          kernel_load,
  output logic                          valid_out,
  output logic [7:0]                    win_row,
  output logic [7:0]                    win_col
);
  localparam int NL = 4;
  localparam int RW = $clog2(IMG_H) + 1;
  localparam int CW = $clog2(IMG_W) + 1;
`ifdef CONV_FEED_ZERO_PAD_EN
  localparam int P = PADDING;
`else
  localparam int P = 0 * PADDING;  // border compiled out
`endif
  localparam logic signed [15:0] RMIN  = 16'(-P);
  localparam logic signed [15:0] RMAX  = 16'(IMG_H + P - 1);
  localparam logic signed [15:0] CMAX  = 16'(IMG_W + P - KERNEL_SIZE);
  localparam logic signed [15:0] RDONE = 16'(KERNEL_SIZE - 1 - P);

  typedef enum logic [1:0] {IDLE, KLOAD, STREAM, DRAIN} state_e;

  state_e                        state_q;
  logic [1:0]                    kcnt_q;
  logic signed [15:0]            r_q, c_q;
  logic                          slot_q;
  logic [3:0]                    vld_pipe;
  logic [3:0][7:0]               wr_pipe, wc_pipe;
  logic                          img_rd;
  logic [NL-1:0]                 lane_ok;
  logic [NL-1:0][DATA_WIDTH-1:0] lane_data;

`ifdef CONV_FEED_ZERO_PAD_EN
  localparam logic signed [15:0] H_S = 16'(IMG_H);
  localparam logic signed [15:0] W_S = 16'(IMG_W);
  logic [NL-1:0]      slot_mask, mask_s_q, lane_ok_q;
  logic signed [15:0] lane_col;

  always_comb begin
    img_rd    = (r_q >= 16'sd0) && (r_q < H_S);
    slot_mask = '0;
    lane_col  = c_q;
    for (int l = 0; l < NL; l++) begin
      lane_col     = c_q + 16'(l);
      slot_mask[l] = img_rd && (lane_col >= 16'sd0) && (lane_col < W_S);
    end
    if (state_q == KLOAD) slot_mask = '1;
  end

  // Mask follows the slot by one cycle so it lines up with the returning read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_s_q  <= '0;
      lane_ok_q <= '0;
    end else begin
      mask_s_q  <= slot_mask;
      lane_ok_q <= slot_q ? mask_s_q : '0;
    end
  end
  assign lane_ok = lane_ok_q;
`else
  assign img_rd  = 1'b1;
  assign lane_ok = {NL{valid_in}};
`endif

  for (genvar l = 0; l < NL; l++) begin : g_lane
    conv4_feed_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .lane_ok_i (lane_ok[l]),
      .raw_i     (mem_rd_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .data_o    (lane_data[l])
    );
  end

  assign data_in0  = lane_data[0];
  assign data_in1  = lane_data[1];
  assign data_in2  = lane_data[2];
  assign data_in3  = lane_data[3];
  assign valid_out = vld_pipe[3];
  assign win_row   = wr_pipe[3];
  assign win_col   = wc_pipe[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      kcnt_q         <= '0;
      r_q            <= '0;
      c_q            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      slot_q         <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_kernel_sel <= 1'b0;
      mem_row        <= '0;
      mem_col        <= '0;
      valid_in       <= 1'b0;
      kernel_load    <= 1'b0;
      vld_pipe       <= '0;
      wr_pipe        <= '0;
      wc_pipe        <= '0;
    end else begin
      slot_q      <= 1'b0;
      mem_rd_en   <= 1'b0;
      done        <= 1'b0;
      valid_in    <= slot_q;
      kernel_load <= slot_q & mem_kernel_sel;
      vld_pipe    <= {vld_pipe[2:0], 1'b0};
      wr_pipe     <= {wr_pipe[2:0], 8'd0};
      wc_pipe     <= {wc_pipe[2:0], 8'd0};
      case (state_q)
        IDLE: if (start) begin
          state_q <= KLOAD;
          busy    <= 1'b1;
          kcnt_q  <= '0;
        end
        KLOAD: begin
          slot_q         <= 1'b1;
          mem_rd_en      <= 1'b1;
          mem_kernel_sel <= 1'b1;
          mem_row        <= RW'(kcnt_q);
          mem_col        <= '0;
          kcnt_q         <= kcnt_q + 2'd1;
          if (kcnt_q == 2'd3) begin
            state_q <= STREAM;
            r_q     <= RMIN;
            c_q     <= RMIN;
          end
        end
        STREAM: begin
          slot_q         <= 1'b1;
          mem_rd_en      <= img_rd;
          mem_kernel_sel <= 1'b0;
          mem_row        <= r_q[RW-1:0];
          mem_col        <= c_q[CW-1:0];
          vld_pipe[0]    <= (r_q >= RDONE);
          wr_pipe[0]     <= 8'(r_q - RDONE);
          wc_pipe[0]     <= 8'(c_q - RMIN);
          if (r_q == RMAX) begin
            r_q <= RMIN;
            if (c_q == CMAX) state_q <= DRAIN;
            else             c_q     <= c_q + 16'sd1;
          end else begin
            r_q <= r_q + 16'sd1;
          end
        end
        DRAIN: if (!slot_q && !valid_in && !vld_pipe[2]) begin
          // Last capture pulse is on valid_out this cycle; done lands right after it.
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv4_window_feeder.sv
// Self-checking bench for conv4_window_feeder: memory model, beat/window scoreboards, cycle-offset table.
module tb_conv4_window_feeder;
`ifdef CONV_FEED_ZERO_PAD_EN
  localparam int H = 4, W = 4, P = 1;
`else
  localparam int H = 6, W = 6, P = 0;
`endif
  localparam int OH = H + 2*P - 3, OW = W + 2*P - 3, N = OW * (H + 2*P);
  localparam int RW = $clog2(H) + 1, CW = $clog2(W) + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, mem_rd_en, mem_kernel_sel, valid_in, kernel_load, valid_out;
  logic [RW-1:0] mem_row;
  logic signed [CW-1:0] mem_col;
  logic [63:0] mem_rd_data = '0;
  logic [15:0] d0, d1, d2, d3;
  logic [7:0] win_row, win_col;

  conv4_window_feeder #(.DATA_WIDTH(16), .KERNEL_SIZE(4), .IMG_H(H), .IMG_W(W), .PADDING(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_kernel_sel(mem_kernel_sel), .mem_row(mem_row), .mem_col(mem_col),
    .mem_rd_data(mem_rd_data), .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3),
    .valid_in(valid_in), .kernel_load(kernel_load), .valid_out(valid_out),
    .win_row(win_row), .win_col(win_col)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, t0 = 0;
  int vo_cnt, first_vo, last_vo, done_cnt, done_at, rd_cnt;
  logic busy_at_done;
  bit mon_en = 1'b0;

  typedef struct packed {logic kl; logic [63:0] d;} beat_t;
  beat_t bq[$];
  logic [15:0] wq[$];

  typedef struct {logic busy, rd, sel, vi, kl, chk_row; int row;} seq_t;
  seq_t tab[7];

  function automatic logic [15:0] pix(input int r, input int c);
    return 16'h1000 | 16'(r*64 + c);
  endfunction

  // Out-of-image lanes return garbage so masking is visible.
  function automatic logic [63:0] mem_word(input logic sel, input int row, input int col);
    logic [63:0] w;
    for (int l = 0; l < 4; l++) begin
      if (sel) w[16*l +: 16] = 16'hA000 | 16'(row*16 + l);
      else if (row >= H || col + l < 0 || col + l >= W) w[16*l +: 16] = 16'hDEAD;
      else w[16*l +: 16] = pix(row, col + l);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem_rd_en ? mem_word(mem_kernel_sel, int'(mem_row), int'(mem_col)) : {$urandom, $urandom};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (mon_en) begin
      if (valid_in) begin
        if (bq.size() == 0) chk("beat_unexpected", valid_in, 0);
        else begin
          e = bq.pop_front();
          chk("beat", {kernel_load, d3, d2, d1, d0}, {e.kl, e.d});
        end
      end
      if (valid_out) begin
        vo_cnt++;
        if (first_vo < 0) first_vo = cyc - t0;
        last_vo = cyc - t0;
        if (wq.size() == 0) chk("window_unexpected", valid_out, 0);
        else chk("window", {win_row, win_col}, wq.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_at = cyc - t0;
        busy_at_done = busy;
      end
      if (mem_rd_en) rd_cnt++;
    end
  end

  task automatic push_expected();
    logic [63:0] d;
    for (int k = 0; k < 4; k++) bq.push_back({1'b1, mem_word(1'b1, k, 0)});
    for (int c = -P; c <= W + P - 4; c++)
      for (int r = -P; r <= H + P - 1; r++) begin
        for (int l = 0; l < 4; l++)
          d[16*l +: 16] = (r < 0 || r >= H || c + l < 0 || c + l >= W) ? 16'h0000 : pix(r, c + l);
        bq.push_back({1'b0, d});
      end
    for (int k = 0; k < OH*OW; k++) wq.push_back({8'(k % OH), 8'(k / OH)});
  endtask

  task automatic run(input bit extra_start);
    push_expected();
    vo_cnt = 0; first_vo = -1; last_vo = -1; done_cnt = 0; done_at = -1; rd_cnt = 0; busy_at_done = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0; t0 = cyc;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("seq_cycle%0d", i),
          {busy, mem_rd_en, valid_in, kernel_load, (tab[i].rd ? mem_kernel_sel : 1'b0), (tab[i].chk_row ? int'(mem_row) : 0)},
          {tab[i].busy, tab[i].rd, tab[i].vi, tab[i].kl, tab[i].sel, tab[i].row});
    end
    if (extra_start) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    for (int k = 0; k < 200 && done_cnt == 0; k++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("valid_out_count", vo_cnt, OH*OW);
    chk("first_valid_out_cycle", first_vo, 11);
    chk("last_valid_out_cycle", last_vo, 7 + N);
    chk("done_cycle", done_at, 8 + N);
    chk("busy_at_done", busy_at_done, 0);
    chk("read_count", rd_cnt, 4 + OW*H);
    chk("beats_left", bq.size(), 0);
    chk("windows_left", wq.size(), 0);
  endtask

  initial begin
    int activity;
    tab[0] = '{1, 0, 0, 0, 0, 0, 0};
    tab[1] = '{1, 1, 1, 0, 0, 1, 0};
    tab[2] = '{1, 1, 1, 1, 1, 1, 1};
    tab[3] = '{1, 1, 1, 1, 1, 1, 2};
    tab[4] = '{1, 1, 1, 1, 1, 1, 3};
    tab[5] = '{1, (P == 0), 0, 1, 1, (P == 0), 0};
    tab[6] = '{1, 1, 0, 1, 0, 1, (P == 0) ? 1 : 0};

    rst = 1'b1; start = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("reset_outputs", {busy, done, mem_rd_en, valid_in, kernel_load, valid_out, mem_row, mem_col, win_row, win_col, d3, d2, d1, d0}, '0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, mem_rd_en, valid_in}, 0);
    mon_en = 1'b1;

    run(1'b0);
    run(1'b1);

    // Abort a run mid-stream, then expect silence and a clean rerun.
    mon_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bq.delete(); wq.delete();
    activity = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_in || valid_out || done || busy || mem_rd_en) activity++;
    end
    chk("quiet_after_mid_reset", activity, 0);
    mon_en = 1'b1;
    run(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
